// File: rtl/leaf_pkg.sv
// rtl/leaf_pkg.sv - shared leaf packet field layout and arbiter operation codes
package leaf_pkg;

  localparam int PACKET_BITS   = 97;
  localparam int NUM_LEAF_BITS = 6;
  localparam int NUM_PORT_BITS = 4;

  // Packet field positions, counted down from the valid bit
  localparam int VLD_POS  = PACKET_BITS - 1;
  localparam int LEAF_MSB = VLD_POS - 1;
  localparam int LEAF_LSB = LEAF_MSB - NUM_LEAF_BITS + 1;
  localparam int PORT_MSB = LEAF_LSB - 1;
  localparam int PORT_LSB = PORT_MSB - NUM_PORT_BITS + 1;

  // Port numbering classes: inputs occupy 0..8, outputs start at 9
  localparam int INPUT_PORT_MAX_NUM  = 8;
  localparam int OUTPUT_PORT_MIN_NUM = 9;

  // What the output register does on the coming edge
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_SEND = 2'd1,
    OP_HOLD = 2'd2
  } arb_op_e;

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// rtl/leaf_out_arbiter_if.sv - requester and BFT-side signals of the leaf output arbiter
interface leaf_out_arbiter_if #(
  parameter int PACKET_BITS = 97,
  parameter int NUM_REQ     = 4
);
  logic [NUM_REQ*PACKET_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [PACKET_BITS-1:0]         dout_leaf_interface2bft;
  logic                           resend;

  // Producers and BFT model side
  modport master (
    output req_data, req_valid, resend,
    input  req_ready, dout_leaf_interface2bft
  );

  // Arbiter side
  modport slave (
    input  req_data, req_valid, resend,
    output req_ready, dout_leaf_interface2bft
  );
endinterface

// File: rtl/leaf_out_arbiter_rr_pick.sv
// rtl/leaf_out_arbiter_rr_pick.sv - combinational cyclic first-one finder with optional priority for index 0
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_BITS-1:0] start,
  input  logic                prio0,
  output logic [IDX_BITS-1:0] winner,
  output logic                any
);

  // Scan from start upward, wrapping at NUM_REQ-1; the first set bit wins
  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    any    = |req;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        winner = IDX_BITS'(idx);
        found  = 1'b1;
      end
    end
    if (prio0 && req[0]) winner = '0;
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// rtl/leaf_out_arbiter.sv - shares the leaf-to-BFT output register among several packet sources
module leaf_out_arbiter
  import leaf_pkg::*;
#(
  parameter int PACKET_BITS    = 97,
  parameter int NUM_REQ        = 4,
  parameter int REQ_IDX_BITS   = 2,
  parameter int PRIO0          = 0,
  parameter int RETRY_LIMIT    = 255,
  parameter int STALL_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  leaf_out_arbiter_if.slave         bus,
  output logic                      busy,
  output logic [REQ_IDX_BITS-1:0]   grant_idx,
  output logic [STALL_CNT_BITS-1:0] stall_cycles,
  output logic                      retry_timeout
);

  localparam int HR_BITS = $clog2(RETRY_LIMIT + 1);

  logic [PACKET_BITS-1:0]  dout_q;
  logic [PACKET_BITS-1:0]  sel_pkt;
  logic [REQ_IDX_BITS-1:0] rr_ptr;
  logic [REQ_IDX_BITS-1:0] winner;
  logic [HR_BITS-1:0]      hold_run;
  logic [NUM_REQ-1:0]      ready;
  logic                    any_req;
  logic                    out_vld;
  logic                    hold;
  logic                    load_en;
  arb_op_e                 op;

  assign out_vld = dout_q[PACKET_BITS-1];
  assign busy    = out_vld;
  // resend only matters when there is something on dout to re-drive
  assign hold    = out_vld & bus.resend;
  assign load_en = !hold;

  assign bus.dout_leaf_interface2bft = dout_q;
  assign bus.req_ready               = ready;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (REQ_IDX_BITS)
  ) u_pick (
    .req    (bus.req_valid),
    .start  (rr_ptr),
    .prio0  (PRIO0 != 0),
    .winner (winner),
    .any    (any_req)
  );

  assign sel_pkt = bus.req_data[int'(winner)*PACKET_BITS +: PACKET_BITS];

  // Classify the coming edge as hold, send or idle
  always_comb begin
    op = OP_IDLE;
    if (hold)         op = OP_HOLD;
    else if (any_req) op = OP_SEND;
  end

  // Accept the winner whenever the output register is free to load
  always_comb begin
    ready = '0;
    if (!reset && op == OP_SEND) ready[winner] = 1'b1;
  end

  // Output register, round-robin pointer and stall/timeout bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q        <= '0;
      grant_idx     <= '0;
      rr_ptr        <= '0;
      stall_cycles  <= '0;
      hold_run      <= '0;
      retry_timeout <= 1'b0;
    end else begin
      case (op)
        OP_HOLD: begin
          if (stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
          if (int'(hold_run) + 1 == RETRY_LIMIT) retry_timeout <= 1'b1;
          if (hold_run != HR_BITS'(RETRY_LIMIT)) hold_run <= hold_run + 1'b1;
        end
        OP_SEND: begin
          dout_q    <= {1'b1, sel_pkt[PACKET_BITS-2:0]};
          grant_idx <= winner;
          rr_ptr    <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
          hold_run  <= '0;
        end
        default: begin
          dout_q   <= '0;
          hold_run <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb/tb_leaf_out_arbiter.sv - randomized and directed checks of leaf_out_arbiter against a reference model
module tb_leaf_out_arbiter;

  localparam int PB = 97;
  localparam int NR = 4;
  localparam int RL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  leaf_out_arbiter_if #(.PACKET_BITS(PB), .NUM_REQ(NR)) ifa ();
  leaf_out_arbiter_if #(.PACKET_BITS(PB), .NUM_REQ(NR)) ifb ();

  logic        busy_a, busy_b, to_a, to_b;
  logic [1:0]  grant_a, grant_b;
  logic [15:0] stall_a, stall_b;

  leaf_out_arbiter #(.PACKET_BITS(PB), .NUM_REQ(NR), .REQ_IDX_BITS(2), .PRIO0(0),
                     .RETRY_LIMIT(RL), .STALL_CNT_BITS(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave), .busy(busy_a), .grant_idx(grant_a),
    .stall_cycles(stall_a), .retry_timeout(to_a));

  leaf_out_arbiter #(.PACKET_BITS(PB), .NUM_REQ(NR), .REQ_IDX_BITS(2), .PRIO0(1),
                     .RETRY_LIMIT(RL), .STALL_CNT_BITS(16)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave), .busy(busy_b), .grant_idx(grant_b),
    .stall_cycles(stall_b), .retry_timeout(to_b));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus packets and reference state, index 0 = round-robin, 1 = priority-0 instance
  logic [PB-1:0] data [NR];
  logic [PB-1:0] m_dout [2];
  int            m_grant [2];
  int            m_rr [2];
  int            m_stall [2];
  int            m_hr [2];
  bit            m_to [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int m, input logic [NR-1:0] v);
    if (m == 1 && v[0]) return 0;
    for (int k = 0; k < NR; k++) begin
      if (v[(m_rr[m] + k) % NR]) return (m_rr[m] + k) % NR;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_dout[m] = '0; m_grant[m] = 0; m_rr[m] = 0;
      m_stall[m] = 0; m_hr[m] = 0; m_to[m] = 1'b0;
    end
  endfunction

  // One clock: drive inputs after the falling edge, check ready, clock, check registers
  task automatic step(input bit r, input logic [NR-1:0] v, input bit rs);
    logic [NR-1:0] exp_rdy [2];
    logic [NR-1:0] obs_rdy [2];
    logic [PB-1:0] obs_dout [2];
    int            obs_grant [2];
    int            obs_stall [2];
    bit            obs_busy [2];
    bit            obs_to [2];
    int            w [2];
    bit            hold [2];
    @(negedge clk);
    reset = r;
    ifa.req_valid = v; ifb.req_valid = v;
    ifa.resend = rs;   ifb.resend = rs;
    for (int i = 0; i < NR; i++) begin
      ifa.req_data[i*PB +: PB] = data[i];
      ifb.req_data[i*PB +: PB] = data[i];
    end
    #1;
    obs_rdy[0] = ifa.req_ready; obs_rdy[1] = ifb.req_ready;
    for (int m = 0; m < 2; m++) begin
      w[m]    = pick(m, v);
      hold[m] = m_dout[m][PB-1] && rs;
      exp_rdy[m] = (r || hold[m] || w[m] < 0) ? '0 : NR'(1) << w[m];
      chk($sformatf("req_ready[%0d]", m), 128'(obs_rdy[m]), 128'(exp_rdy[m]));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        m_dout[m] = '0; m_grant[m] = 0; m_rr[m] = 0;
        m_stall[m] = 0; m_hr[m] = 0; m_to[m] = 1'b0;
      end else if (hold[m]) begin
        if (m_stall[m] < 65535) m_stall[m]++;
        if (m_hr[m] + 1 == RL) m_to[m] = 1'b1;
        m_hr[m]++;
      end else if (w[m] >= 0) begin
        m_dout[m] = data[w[m]];
        m_dout[m][PB-1] = 1'b1;
        m_grant[m] = w[m];
        m_rr[m] = (w[m] + 1) % NR;
        m_hr[m] = 0;
      end else begin
        m_dout[m] = '0;
        m_hr[m] = 0;
      end
    end
    #1;
    obs_dout[0] = ifa.dout_leaf_interface2bft; obs_dout[1] = ifb.dout_leaf_interface2bft;
    obs_grant[0] = int'(grant_a); obs_grant[1] = int'(grant_b);
    obs_stall[0] = int'(stall_a); obs_stall[1] = int'(stall_b);
    obs_busy[0] = busy_a; obs_busy[1] = busy_b;
    obs_to[0] = to_a; obs_to[1] = to_b;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("dout[%0d]", m), 128'(obs_dout[m]), 128'(m_dout[m]));
      chk($sformatf("grant_idx[%0d]", m), 128'(obs_grant[m]), 128'(m_grant[m]));
      chk($sformatf("busy[%0d]", m), 128'(obs_busy[m]), 128'(m_dout[m][PB-1]));
      chk($sformatf("stall_cycles[%0d]", m), 128'(obs_stall[m]), 128'(m_stall[m]));
      chk($sformatf("retry_timeout[%0d]", m), 128'(obs_to[m]), 128'(m_to[m]));
    end
  endtask

  initial begin
    logic [PB-1:0] pkt;
    int rr_seq [6];
    int pr_seq [4];
    rr_seq = '{0, 1, 2, 3, 0, 1};
    pr_seq = '{0, 1, 3, 0};
    ifa.req_valid = '0; ifb.req_valid = '0;
    ifa.resend = 1'b0;  ifb.resend = 1'b0;
    ifa.req_data = '0;  ifb.req_data = '0;
    for (int i = 0; i < NR; i++) data[i] = '0;
    model_reset();

    // Reset then idle
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    chk("idle_busy", 128'(busy_a), 128'(0));

    // Round-robin with every requester valid
    for (int i = 0; i < NR; i++) data[i] = PB'(i);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'b1111, 1'b0);
      chk("rr_seq", 128'(grant_a), 128'(rr_seq[k]));
      chk("rr_vld", 128'(ifa.dout_leaf_interface2bft[PB-1]), 128'(1));
      chk("prio_all", 128'(grant_b), 128'(0));
    end

    // Resend hold of a single packet from requester 2
    data[2] = PB'(12'hABC);
    pkt = data[2];
    pkt[PB-1] = 1'b1;
    step(1'b0, 4'b0100, 1'b0);
    chk("hold_load", 128'(ifa.dout_leaf_interface2bft), 128'(pkt));
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0000, 1'b1);
      chk("hold_dout", 128'(ifa.dout_leaf_interface2bft), 128'(pkt));
    end
    chk("hold_stall", 128'(stall_a), 128'(3));
    step(1'b0, 4'b0000, 1'b0);

    // Priority versus round-robin on the same request pattern
    step(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b1011, 1'b0);
      chk("rr_1011", 128'(grant_a), 128'(pr_seq[k]));
      chk("prio_1011", 128'(grant_b), 128'(0));
    end

    // Retry timeout after RL consecutive holds, sticky until reset
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 1'b1);
    chk("to_before", 128'(to_a), 128'(0));
    step(1'b0, 4'b0000, 1'b1);
    chk("to_rise", 128'(to_a), 128'(1));
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    chk("to_sticky", 128'(to_a), 128'(1));

    // Reset in the middle of a hold discards the pending packet
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    chk("rst_hold_dout", 128'(ifa.dout_leaf_interface2bft), 128'(0));
    chk("rst_hold_to", 128'(to_a), 128'(0));
    step(1'b0, 4'b1111, 1'b0);
    chk("post_rst_grant", 128'(grant_a), 128'(0));

    // Random traffic with random resend and rare resets
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) data[i] = PB'({$urandom, $urandom, $urandom, $urandom});
      step(($urandom % 60) == 0, NR'($urandom), ($urandom % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
